// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: MemOp codes, FSM states,
// byte-enable constants and store-lane / alignment helpers.
package mem_pkg;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  // The unsigned-load codes have no store meaning, so stores fall back to word.
  function automatic size_t access_size(input logic [2:0] op, input logic is_store);
    size_t sz;
    case (op)
      OP_B:    sz = SZ_B;
      OP_H:    sz = SZ_H;
      OP_BU:   sz = is_store ? SZ_W : SZ_B;
      OP_HU:   sz = is_store ? SZ_W : SZ_H;
      default: sz = SZ_W;
    endcase
    return sz;
  endfunction

  function automatic logic [3:0] store_be(input size_t sz, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (sz)
      SZ_B:    be = BE_BYTE0 << addr_lo;
      SZ_H:    be = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
      default: be = BE_WORD;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_wdata(input size_t sz, input logic [31:0] data);
    logic [31:0] wd;
    case (sz)
      SZ_B:    wd = {4{data[7:0]}};
      SZ_H:    wd = {2{data[15:0]}};
      default: wd = data;
    endcase
    return wd;
  endfunction

  function automatic logic misaligned(input size_t sz, input logic [1:0] addr_lo);
    logic bad;
    case (sz)
      SZ_H:    bad = addr_lo[0];
      SZ_W:    bad = (addr_lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it
// according to the load MemOp.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  mem_op,
  output logic [31:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select and extension.
  always_comb begin
    byte_s = rdata[{addr, 3'b000} +: 8];
    half_s = addr[1] ? rdata[31:16] : rdata[15:0];
    case (mem_op)
      OP_B:    data = {{24{byte_s[7]}}, byte_s};
      OP_BU:   data = {24'h000000, byte_s};
      OP_H:    data = {{16{half_s[15]}}, half_s};
      OP_HU:   data = {16'h0000, half_s};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: req/ack data-memory transactions with stall,
// timeout abort and registered write-back. Optional MEM_MISALIGN_TRAP_EN adds misalign_err.
module mem_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_ALUout,
  input  logic [31:0] in_busB,
  input  logic [2:0]  in_MemOp,
  input  logic [4:0]  in_rd,
  input  logic        in_MemtoReg,
  input  logic        in_RegWr,
  input  logic        in_MemWr,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_RegWr,
  output logic        bus_err
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic        misalign_err
`endif
);

  state_t           state_r, state_nx_s;
  logic [CNT_W-1:0] cnt_r, cnt_nx_s;
  logic [2:0]       op_r;
  logic [1:0]       addr_lo_r;
  logic [4:0]       rd_r;
  logic             regwr_r;
  logic             load_r;
  logic             memop_s;
  logic             misalign_s;
  logic             timeout_hit_s;
  logic             issue_s;
  logic             done_s;
  logic             abort_s;
  size_t            size_s;
  logic [31:0]      load_data_s;

  assign memop_s  = in_MemWr | in_MemtoReg;
  assign size_s   = access_size(in_MemOp, in_MemWr);
  assign cnt_nx_s = cnt_r + CNT_W'(1);
  assign timeout_hit_s = (TIMEOUT_CYCLES != 0) && (cnt_nx_s == CNT_W'(TIMEOUT_CYCLES));
  assign stall    = ((state_r == IDLE) && memop_s) || (state_r == BUSY);

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_s = misaligned(size_s, in_ALUout[1:0]);
`else
  assign misalign_s = 1'b0;
`endif

  load_align u_load_align (
    .rdata  (dmem_rdata),
    .addr   (addr_lo_r),
    .mem_op (op_r),
    .data   (load_data_s)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nx_s;
  end

  // Next-state and transaction decisions; ack takes priority over timeout.
  always_comb begin
    state_nx_s = state_r;
    issue_s    = 1'b0;
    done_s     = 1'b0;
    abort_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (memop_s && misalign_s) begin
          state_nx_s = RESP;
        end else if (memop_s) begin
          issue_s    = 1'b1;
          state_nx_s = BUSY;
        end else begin
          state_nx_s = IDLE;
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          done_s     = 1'b1;
          state_nx_s = RESP;
        end else if (timeout_hit_s) begin
          abort_s    = 1'b1;
          state_nx_s = RESP;
        end else begin
          state_nx_s = BUSY;
        end
      end
      RESP:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Bus request, latched op context, timeout counter and write-back registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'h0000_0000;
      dmem_wdata <= 32'h0000_0000;
      dmem_be    <= 4'b0000;
      wb_data    <= 32'h0000_0000;
      wb_rd      <= 5'd0;
      wb_RegWr   <= 1'b0;
      bus_err    <= 1'b0;
      cnt_r      <= '0;
      op_r       <= 3'b000;
      addr_lo_r  <= 2'b00;
      rd_r       <= 5'd0;
      regwr_r    <= 1'b0;
      load_r     <= 1'b0;
    end else begin
      wb_RegWr <= 1'b0;
      bus_err  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (!memop_s) begin
            wb_data  <= in_ALUout;
            wb_rd    <= in_rd;
            wb_RegWr <= in_RegWr & (in_rd != 5'd0);
          end else if (issue_s) begin
            op_r       <= in_MemOp;
            addr_lo_r  <= in_ALUout[1:0];
            rd_r       <= in_rd;
            regwr_r    <= in_RegWr;
            load_r     <= ~in_MemWr;
            dmem_req   <= 1'b1;
            dmem_we    <= in_MemWr;
            dmem_addr  <= {in_ALUout[31:2], 2'b00};
            dmem_be    <= in_MemWr ? store_be(size_s, in_ALUout[1:0]) : BE_WORD;
            dmem_wdata <= store_wdata(size_s, in_busB);
            cnt_r      <= '0;
          end
        end
        BUSY: begin
          if (done_s) begin
            dmem_req <= 1'b0;
            wb_rd    <= rd_r;
            if (load_r) begin
              wb_data  <= load_data_s;
              wb_RegWr <= regwr_r & (rd_r != 5'd0);
            end
          end else if (abort_s) begin
            dmem_req <= 1'b0;
            bus_err  <= 1'b1;
          end else begin
            cnt_r <= cnt_nx_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // One-cycle trap pulse for a rejected misaligned access.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) misalign_err <= 1'b0;
    else       misalign_err <= (state_r == IDLE) && memop_s && misalign_s;
  end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (default parameters, either
// MEM_MISALIGN_TRAP_EN setting).
module tb_mem_stage;
  import mem_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_ALUout, in_busB;
  logic [2:0]  in_MemOp;
  logic [4:0]  in_rd;
  logic        in_MemtoReg, in_RegWr, in_MemWr;
  logic        stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_RegWr, bus_err;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mem_stage #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
    .clock(clock), .reset(reset),
    .in_ALUout(in_ALUout), .in_busB(in_busB), .in_MemOp(in_MemOp), .in_rd(in_rd),
    .in_MemtoReg(in_MemtoReg), .in_RegWr(in_RegWr), .in_MemWr(in_MemWr),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_RegWr(wb_RegWr), .bus_err(bus_err)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misalign_err(misalign_err)
`endif
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    in_ALUout = 32'h0; in_busB = 32'h0; in_MemOp = 3'b000; in_rd = 5'd0;
    in_MemtoReg = 1'b0; in_RegWr = 1'b0; in_MemWr = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = 32'h0BAD_0BAD;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if ({dmem_req, dmem_we, wb_RegWr, bus_err, stall} !== 5'b00000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {dmem_req, dmem_we, wb_RegWr, bus_err, stall});
    end
    n_checks++;
    if ({dmem_addr, dmem_wdata, wb_data, wb_rd, dmem_be} !== 105'd0) begin
      n_fail++; $display("FAIL reset_data: addr %h wdata %h wb %h rd %0d be %b expected all zero",
                         dmem_addr, dmem_wdata, wb_data, wb_rd, dmem_be);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_nonmem(input logic [31:0] val, input logic [4:0] rd, input logic regwr, input logic exp_regwr);
    in_ALUout = val; in_rd = rd; in_RegWr = regwr; in_MemtoReg = 1'b0; in_MemWr = 1'b0;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL nonmem_stall: got %b expected 0", stall); end
    tick();
    n_checks++;
    if ({wb_data, wb_rd, wb_RegWr} !== {val, rd, exp_regwr} || stall !== 1'b0) begin
      n_fail++; $display("FAIL nonmem_wb: got data %h rd %0d regwr %b stall %b expected %h %0d %b 0",
                         wb_data, wb_rd, wb_RegWr, stall, val, rd, exp_regwr);
    end
  endtask

  task automatic test_load(input string name, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] rdata, input int ack_wait, input logic [31:0] exp_wb);
    in_ALUout = addr; in_MemOp = op; in_MemtoReg = 1'b1; in_MemWr = 1'b0; in_RegWr = 1'b1;
    in_rd = 5'd7; in_busB = 32'hDEAD_0000;
    #1;
    n_checks++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL %s_stall_idle: got %b expected 1", name, stall); end
    tick();
    n_checks++;
    if ({dmem_req, dmem_we, dmem_be, dmem_addr, wb_RegWr} !== {1'b1, 1'b0, 4'b1111, {addr[31:2], 2'b00}, 1'b0}) begin
      n_fail++; $display("FAIL %s_issue: req %b we %b be %b addr %h regwr %b expected 1 0 1111 %h 0",
                         name, dmem_req, dmem_we, dmem_be, dmem_addr, wb_RegWr, {addr[31:2], 2'b00});
    end
    repeat (ack_wait - 1) tick();
    n_checks++;
    if ({dmem_req, dmem_addr, stall} !== {1'b1, {addr[31:2], 2'b00}, 1'b1}) begin
      n_fail++; $display("FAIL %s_hold: req %b addr %h stall %b expected 1 %h 1", name, dmem_req, dmem_addr, stall, {addr[31:2], 2'b00});
    end
    dmem_ack = 1'b1; dmem_rdata = rdata;
    tick();
    dmem_ack = 1'b0; dmem_rdata = 32'h0BAD_0BAD;
    n_checks++;
    if ({wb_data, wb_rd, wb_RegWr, dmem_req, stall, bus_err} !== {exp_wb, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL %s_resp: wb %h rd %0d regwr %b req %b stall %b err %b expected %h 7 1 0 0 0",
                         name, wb_data, wb_rd, wb_RegWr, dmem_req, stall, bus_err, exp_wb);
    end
    tick();
    n_checks++;
    if ({wb_RegWr, dmem_req} !== 2'b00) begin
      n_fail++; $display("FAIL %s_after: regwr %b req %b expected 0 0", name, wb_RegWr, dmem_req);
    end
    idle_inputs();
  endtask

  task automatic test_store(input string name, input logic [2:0] op, input logic [31:0] addr, input logic [31:0] busb,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    in_ALUout = addr; in_MemOp = op; in_MemtoReg = 1'b0; in_MemWr = 1'b1; in_RegWr = 1'b1;
    in_rd = 5'd9; in_busB = busb;
    tick();
    n_checks++;
    if ({dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr} !== {1'b1, 1'b1, exp_be, exp_wdata, {addr[31:2], 2'b00}}) begin
      n_fail++; $display("FAIL %s_issue: req %b we %b be %b wdata %h addr %h expected 1 1 %b %h %h",
                         name, dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr, exp_be, exp_wdata, {addr[31:2], 2'b00});
    end
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    n_checks++;
    if ({wb_RegWr, dmem_req, stall} !== 3'b000) begin
      n_fail++; $display("FAIL %s_resp: regwr %b req %b stall %b expected 0 0 0", name, wb_RegWr, dmem_req, stall);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_timeout();
    int n = 0;
    int err_early = 0;
    in_ALUout = 32'h400; in_MemOp = OP_W; in_MemtoReg = 1'b1; in_RegWr = 1'b1; in_rd = 5'd3;
    tick();
    while (dmem_req === 1'b1 && n < 40) begin
      if (bus_err !== 1'b0) err_early++;
      n++;
      tick();
    end
    n_checks++;
    if (n != 16 || err_early != 0) begin
      n_fail++; $display("FAIL timeout_len: busy cycles %0d early errs %0d expected 16 0", n, err_early);
    end
    n_checks++;
    if ({bus_err, stall, wb_RegWr, dmem_req} !== 4'b1000) begin
      n_fail++; $display("FAIL timeout_resp: err %b stall %b regwr %b req %b expected 1 0 0 0", bus_err, stall, wb_RegWr, dmem_req);
    end
    tick();
    idle_inputs();
    n_checks++;
    if (bus_err !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse: got %b expected 0", bus_err); end
  endtask

  task automatic test_ack_at_limit();
    in_ALUout = 32'h404; in_MemOp = OP_W; in_MemtoReg = 1'b1; in_RegWr = 1'b1; in_rd = 5'd4;
    tick();
    repeat (15) tick();
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    tick();
    dmem_ack = 1'b0;
    n_checks++;
    if ({bus_err, wb_RegWr, wb_data, wb_rd} !== {1'b0, 1'b1, 32'hCAFE_F00D, 5'd4}) begin
      n_fail++; $display("FAIL ack_wins: err %b regwr %b wb %h rd %0d expected 0 1 cafef00d 4", bus_err, wb_RegWr, wb_data, wb_rd);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_busy();
    int pulses = 0;
    in_ALUout = 32'h500; in_MemOp = OP_W; in_MemWr = 1'b1; in_busB = 32'h1111_2222; in_rd = 5'd6; in_RegWr = 1'b1;
    tick();
    reset = 1'b1;
    #1;
    n_checks++;
    if ({dmem_req, wb_RegWr} !== 2'b00) begin
      n_fail++; $display("FAIL reset_busy: req %b regwr %b expected 0 0", dmem_req, wb_RegWr);
    end
    idle_inputs();
    repeat (2) begin
      tick();
      if (wb_RegWr !== 1'b0) pulses++;
    end
    reset = 1'b0;
    tick();
    if (wb_RegWr !== 1'b0) pulses++;
    n_checks++;
    if (pulses != 0 || stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: regwr pulses %0d stall %b expected 0 0", pulses, stall);
    end
  endtask

  task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
    in_ALUout = 32'h101; in_MemOp = OP_W; in_MemtoReg = 1'b1; in_RegWr = 1'b1; in_rd = 5'd8;
    #1;
    n_checks++;
    if (stall !== 1'b1) begin n_fail++; $display("FAIL misalign_stall: got %b expected 1", stall); end
    tick();
    n_checks++;
    if ({dmem_req, misalign_err, wb_RegWr, stall} !== 4'b0100) begin
      n_fail++; $display("FAIL misalign_trap: req %b err %b regwr %b stall %b expected 0 1 0 0", dmem_req, misalign_err, wb_RegWr, stall);
    end
    tick();
    idle_inputs();
    n_checks++;
    if ({dmem_req, misalign_err} !== 2'b00) begin
      n_fail++; $display("FAIL misalign_pulse: req %b err %b expected 0 0", dmem_req, misalign_err);
    end
`else
    test_load("lw_misalign", OP_W, 32'h101, 32'h1357_9BDF, 1, 32'h1357_9BDF);
`endif
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nonmem(32'h0000_1234, 5'd5, 1'b1, 1'b1);
    test_nonmem(32'hFFFF_0001, 5'd0, 1'b1, 1'b0);
    test_load("lb", OP_B, 32'h103, 32'h80FF_FFFF, 2, 32'hFFFF_FF80);
    test_load("lbu", OP_BU, 32'h103, 32'h80FF_FFFF, 2, 32'h0000_0080);
    test_load("lh", OP_H, 32'h002, 32'h8001_7FFF, 1, 32'hFFFF_8001);
    test_load("lhu", OP_HU, 32'h002, 32'h8001_7FFF, 3, 32'h0000_8001);
    test_store("sh", OP_H, 32'h202, 32'hAAAA_BEEF, 4'b1100, 32'hBEEF_BEEF);
    test_store("sb", OP_B, 32'h301, 32'h1234_5678, 4'b0010, 32'h7878_7878);
    test_store("sw", OP_W, 32'h304, 32'hA5A5_5A5A, 4'b1111, 32'hA5A5_5A5A);
    test_timeout();
    test_ack_at_limit();
    test_reset_busy();
    test_load("lw_after_reset", OP_W, 32'h600, 32'h0102_0304, 1, 32'h0102_0304);
    test_nonmem(32'h0000_BEEF, 5'd31, 1'b1, 1'b1);
    test_misalign();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
